// File: rtl/flash_reader.sv
// -----------------------------------------------------------------------------
// flash_reader
//   Serves byte lookups from an external SPI NOR flash using the standard
//   READ command (opcode, 24-bit address, one data byte). A one-entry tag
//   cache answers repeated lookups of the same address with no bus traffic.
//
// Parameters
//   CLK_DIV   SCK half-period in clk cycles (1..255)
//   READ_CMD  flash read opcode, shifted out first
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   fd_address  requested byte address
//   fd_valid    request level
//   fd_ready    fd holds the byte for the presented fd_address (combinational)
//   fd          returned data byte (also the cache data entry)
//   busy        an SPI transaction is in progress
//   spi_cs_n    flash chip select, active low
//   spi_sck     SPI clock, mode 0
//   spi_mosi    command/address to flash, MSB first
//   spi_miso    data from flash
// -----------------------------------------------------------------------------
module flash_reader #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] fd_address,
  input  logic        fd_valid,
  output logic        fd_ready,
  output logic [7:0]  fd,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  // Deselect counter restarts at 0 on the completion edge, so reaching
  // 2*CLK_DIV-1 means chip select has been high for 2*CLK_DIV cycles by the
  // time the next accept edge arrives.
  localparam logic [8:0] DESEL_LAST = 9'(2 * CLK_DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_reg;
  logic [23:0] tag_addr_reg;
  logic        tag_valid_reg;
  logic [31:0] shift_reg;
  logic [7:0]  rx_reg;
  logic [7:0]  div_cnt_reg;
  logic [5:0]  bit_cnt_reg;
  logic [8:0]  desel_cnt_reg;

  logic hit;
  logic desel_done;
  logic half_tick;

  assign hit        = tag_valid_reg && (fd_address == tag_addr_reg);
  assign desel_done = (desel_cnt_reg == DESEL_LAST);
  assign half_tick  = (div_cnt_reg == DIV_LAST);
  assign fd_ready   = fd_valid && hit && (state_reg == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      tag_addr_reg  <= '0;
      tag_valid_reg <= 1'b0;
      shift_reg     <= '0;
      rx_reg        <= '0;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      desel_cnt_reg <= DESEL_LAST;
      fd            <= '0;
      busy          <= 1'b0;
      spi_cs_n      <= 1'b1;
      spi_sck       <= 1'b0;
      spi_mosi      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!desel_done) begin
            desel_cnt_reg <= desel_cnt_reg + 9'd1;
          end
          if (fd_valid && !hit && desel_done) begin
            state_reg     <= SHIFT;
            tag_addr_reg  <= fd_address;
            tag_valid_reg <= 1'b0;
            shift_reg     <= {READ_CMD, fd_address};
            spi_mosi      <= READ_CMD[7];
            spi_cs_n      <= 1'b0;
            busy          <= 1'b1;
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
          end
        end

        SHIFT: begin
          if (!half_tick) begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end else begin
            div_cnt_reg <= '0;
            if (!spi_sck) begin
              // Rising edge: data bits occupy positions 32..39.
              spi_sck <= 1'b1;
              if (bit_cnt_reg >= 6'd32) begin
                rx_reg <= {rx_reg[6:0], spi_miso};
              end
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt_reg == 6'd39) begin
                state_reg     <= IDLE;
                spi_cs_n      <= 1'b1;
                spi_mosi      <= 1'b0;
                busy          <= 1'b0;
                fd            <= rx_reg;
                tag_valid_reg <= 1'b1;
                desel_cnt_reg <= '0;
              end else begin
                // Zeros shift in behind the address, so MOSI idles at 0
                // during the data phase without extra logic.
                bit_cnt_reg <= bit_cnt_reg + 6'd1;
                shift_reg   <= {shift_reg[30:0], 1'b0};
                spi_mosi    <= shift_reg[30];
              end
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_reader.sv
module tb_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst;
  logic [1:0][23:0]  addr;
  logic [1:0]        valid;
  logic [1:0]        ready;
  logic [1:0][7:0]   fd;
  logic [1:0]        busy;
  logic [1:0]        cs_n;
  logic [1:0]        sck;
  logic [1:0]        mosi;
  logic [1:0]        miso;

  int          txn_cnt [2];
  logic [31:0] rx_word [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] flash_mem(input logic [23:0] a);
    case (a)
      24'h001234: flash_mem = 8'hA5;
      24'h000077: flash_mem = 8'h3C;
      24'hFFFFFF: flash_mem = 8'h81;
      default:    flash_mem = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // Instance 0 runs at CLK_DIV=2, instance 1 at CLK_DIV=1; each has its own
  // behavioral SPI flash.
  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    flash_reader #(.CLK_DIV(gi == 0 ? 2 : 1), .READ_CMD(8'h03)) u_dut (
      .clk        (clk),
      .rst        (rst[gi]),
      .fd_address (addr[gi]),
      .fd_valid   (valid[gi]),
      .fd_ready   (ready[gi]),
      .fd         (fd[gi]),
      .busy       (busy[gi]),
      .spi_cs_n   (cs_n[gi]),
      .spi_sck    (sck[gi]),
      .spi_mosi   (mosi[gi]),
      .spi_miso   (miso[gi])
    );

    int          bit_cnt;
    logic [31:0] rx;
    logic [7:0]  dbyte;

    initial begin
      txn_cnt[gi] = 0;
      rx_word[gi] = '0;
      bit_cnt     = 0;
      rx          = '0;
      dbyte       = '0;
      miso[gi]    = 1'b0;
    end

    always @(negedge cs_n[gi]) begin
      bit_cnt = 0;
      txn_cnt[gi] = txn_cnt[gi] + 1;
    end

    always @(posedge sck[gi]) begin
      if (!cs_n[gi]) begin
        if (bit_cnt < 32) rx = {rx[30:0], mosi[gi]};
        bit_cnt = bit_cnt + 1;
        if (bit_cnt == 32) begin
          rx_word[gi] = rx;
          dbyte = flash_mem(rx[23:0]);
        end
      end
    end

    always @(negedge sck[gi]) begin
      if (!cs_n[gi] && bit_cnt >= 32 && bit_cnt < 40) begin
        miso[gi] = dbyte[3'(39 - bit_cnt)];
      end
    end
  end

  // From the current negedge (n0 cycles after accept), step until fd_ready
  // rises; reports accept-to-ready latency and the number of sampled cycles
  // with chip select low (cycles before n0 are assumed low).
  task automatic wait_ready(input int inst, input int n0, input int limit,
                            output int lat, output int cs_low);
    lat = -1;
    cs_low = n0;
    for (int n = n0; n <= limit; n++) begin
      if (n > n0) @(negedge clk);
      if (ready[inst] === 1'b1) begin
        lat = n;
        break;
      end
      if (cs_n[inst] === 1'b0) cs_low++;
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    valid = 2'b11;
    addr[0] = 24'h000000;
    addr[1] = 24'h000000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (cs_n[i] !== 1'b1) begin errors++; $display("FAIL reset_cs_n inst %0d got %b expected 1", i, cs_n[i]); end
      checks++; if (sck[i] !== 1'b0) begin errors++; $display("FAIL reset_sck inst %0d got %b expected 0", i, sck[i]); end
      checks++; if (mosi[i] !== 1'b0) begin errors++; $display("FAIL reset_mosi inst %0d got %b expected 0", i, mosi[i]); end
      checks++; if (fd[i] !== 8'h00) begin errors++; $display("FAIL reset_fd inst %0d got %h expected 00", i, fd[i]); end
      checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d got %b expected 0", i, busy[i]); end
      checks++; if (ready[i] !== 1'b0) begin errors++; $display("FAIL reset_ready inst %0d got %b expected 0", i, ready[i]); end
    end
    valid = 2'b00;
    rst = 2'b00;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_cold_miss();
    int lat, cs_low;
    addr[0] = 24'h001234;
    valid[0] = 1'b1;
    @(negedge clk);
    checks++; if (cs_n[0] !== 1'b0 || busy[0] !== 1'b1) begin errors++; $display("FAIL cold_accept got cs_n=%b busy=%b expected 0/1", cs_n[0], busy[0]); end
    @(negedge clk);
    checks++; if (sck[0] !== 1'b0) begin errors++; $display("FAIL cold_sck_low got %b expected 0", sck[0]); end
    @(negedge clk);
    checks++; if (sck[0] !== 1'b1) begin errors++; $display("FAIL cold_sck_rise got %b expected 1", sck[0]); end
    wait_ready(0, 2, 400, lat, cs_low);
    checks++; if (lat != 160) begin errors++; $display("FAIL cold_latency got %0d expected 160", lat); end
    checks++; if (cs_low != 160) begin errors++; $display("FAIL cold_cs_low got %0d expected 160", cs_low); end
    checks++; if (fd[0] !== 8'hA5) begin errors++; $display("FAIL cold_fd got %h expected a5", fd[0]); end
    checks++; if (rx_word[0] !== 32'h03001234) begin errors++; $display("FAIL cold_mosi got %h expected 03001234", rx_word[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL cold_busy_done got %b expected 0", busy[0]); end
    $display("cold_miss: addr=001234 latency=%0d fd=%h", lat, fd[0]);
  endtask

  task automatic test_hit();
    int t0, bad;
    valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL hit_ready_idle got %b expected 0", ready[0]); end
    t0 = txn_cnt[0];
    valid[0] = 1'b1;
    #1;
    checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL hit_same_cycle got %b expected 1", ready[0]); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cs_n[0] !== 1'b1 || ready[0] !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hit_hold got %0d bad cycles expected 0", bad); end
    checks++; if (txn_cnt[0] != t0) begin errors++; $display("FAIL hit_no_txn got %0d expected %0d", txn_cnt[0], t0); end
    checks++; if (fd[0] !== 8'hA5) begin errors++; $display("FAIL hit_fd got %h expected a5", fd[0]); end
    $display("hit: addr=001234 fd=%h", fd[0]);
  endtask

  task automatic test_addr_change();
    int n, hi, lat, cs_low;
    addr[0] = 24'h000200;
    @(negedge clk);
    checks++; if (cs_n[0] !== 1'b0) begin errors++; $display("FAIL chg_accept got cs_n=%b expected 0", cs_n[0]); end
    n = 0;
    while (n < 400 && cs_n[0] !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n == 50) addr[0] = 24'h000077;
    end
    checks++; if (n != 160) begin errors++; $display("FAIL chg_first_len got %0d expected 160", n); end
    checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL chg_first_ready got %b expected 0", ready[0]); end
    checks++; if (fd[0] !== 8'h58) begin errors++; $display("FAIL chg_first_fd got %h expected 58", fd[0]); end
    checks++; if (rx_word[0] !== 32'h03000200) begin errors++; $display("FAIL chg_first_mosi got %h expected 03000200", rx_word[0]); end
    hi = 0;
    while (hi < 50 && cs_n[0] === 1'b1) begin
      hi++;
      @(negedge clk);
    end
    checks++; if (hi != 4) begin errors++; $display("FAIL chg_desel got %0d expected 4", hi); end
    wait_ready(0, 0, 400, lat, cs_low);
    checks++; if (lat != 160) begin errors++; $display("FAIL chg_second_latency got %0d expected 160", lat); end
    checks++; if (fd[0] !== 8'h3C) begin errors++; $display("FAIL chg_second_fd got %h expected 3c", fd[0]); end
    checks++; if (rx_word[0] !== 32'h03000077) begin errors++; $display("FAIL chg_second_mosi got %h expected 03000077", rx_word[0]); end
    $display("addr_change: first=000200 second=000077 desel=%0d fd=%h", hi, fd[0]);
  endtask

  task automatic test_held();
    int t0, bad;
    t0 = txn_cnt[0];
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ready[0] !== 1'b1 || cs_n[0] !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL held_ready got %0d bad cycles expected 0", bad); end
    checks++; if (txn_cnt[0] != t0) begin errors++; $display("FAIL held_txn got %0d expected %0d", txn_cnt[0], t0); end
    $display("held: 1000 cycles bad=%0d", bad);
  endtask

  task automatic test_reset_mid();
    int lat, cs_low;
    addr[0] = 24'h000300;
    @(negedge clk);
    checks++; if (cs_n[0] !== 1'b0) begin errors++; $display("FAIL rmid_accept got cs_n=%b expected 0", cs_n[0]); end
    repeat (70) @(negedge clk);
    #2 rst[0] = 1'b1;
    #1;
    checks++; if (cs_n[0] !== 1'b1) begin errors++; $display("FAIL rmid_cs_n got %b expected 1", cs_n[0]); end
    checks++; if (sck[0] !== 1'b0) begin errors++; $display("FAIL rmid_sck got %b expected 0", sck[0]); end
    checks++; if (fd[0] !== 8'h00) begin errors++; $display("FAIL rmid_fd got %h expected 00", fd[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b expected 0", busy[0]); end
    checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b expected 0", ready[0]); end
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    checks++; if (cs_n[0] !== 1'b0) begin errors++; $display("FAIL rmid_restart got cs_n=%b expected 0", cs_n[0]); end
    wait_ready(0, 0, 400, lat, cs_low);
    checks++; if (lat != 160) begin errors++; $display("FAIL rmid_latency got %0d expected 160", lat); end
    checks++; if (fd[0] !== 8'h59) begin errors++; $display("FAIL rmid_fd_after got %h expected 59", fd[0]); end
    checks++; if (rx_word[0] !== 32'h03000300) begin errors++; $display("FAIL rmid_mosi got %h expected 03000300", rx_word[0]); end
    $display("reset_mid: restart latency=%0d fd=%h", lat, fd[0]);
  endtask

  task automatic test_div1();
    int lat, cs_low;
    addr[1] = 24'hFFFFFF;
    valid[1] = 1'b1;
    @(negedge clk);
    checks++; if (cs_n[1] !== 1'b0) begin errors++; $display("FAIL div1_accept got cs_n=%b expected 0", cs_n[1]); end
    wait_ready(1, 0, 200, lat, cs_low);
    checks++; if (lat != 80) begin errors++; $display("FAIL div1_latency got %0d expected 80", lat); end
    checks++; if (cs_low != 80) begin errors++; $display("FAIL div1_cs_low got %0d expected 80", cs_low); end
    checks++; if (fd[1] !== 8'h81) begin errors++; $display("FAIL div1_fd got %h expected 81", fd[1]); end
    checks++; if (rx_word[1] !== 32'h03FFFFFF) begin errors++; $display("FAIL div1_mosi got %h expected 03ffffff", rx_word[1]); end
    $display("div1: addr=ffffff latency=%0d fd=%h", lat, fd[1]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11;
    valid = 2'b00;
    addr[0] = '0;
    addr[1] = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_addr_change();
    test_held();
    test_reset_mid();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
